ghost_collision_ctrl: RTL
=========================

# ghost_collision_ctrl

Downstream consumer of the four ghost controllers and the player controller. Each clock it compares every ghost's tile position against the player's, including pass-through swaps. It runs the frightened-mode timer and score chain. It owns the life counter and the freeze/respawn sequence that halts and restarts the maze actors.

## Interface
**Parameters**
- `FRIGHT_TICKS`, default 300: frightened duration, in `tick` strobes.
- `HIT_FREEZE`, default 60: freeze duration after the player is caught, in `tick` strobes.
- `LIVES_INIT`, default 3: lives loaded at reset (1..3).

**Ports**
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle game-tick strobe.
- `player_x` in `width_log2`: player pixel x, a multiple of 20.
- `player_y` in `height_log2`: player pixel y, a multiple of 20.
- `ghost_x` in 4×`width_log2`: packed ghost x; ghost 0 in the LSBs.
- `ghost_y` in 4×`height_log2`: packed ghost y.
- `power_eaten` in 1: one-cycle pulse when a power pellet is consumed.
- `respawn_ack` in 1: actors have been reloaded to start positions.
- `frightened` out 1: frightened mode active.
- `fright_left` out $clog2(FRIGHT_TICKS+1): remaining frightened ticks.
- `ghost_eaten` out 4: one-hot pulse, one cycle, for the ghost just eaten.
- `score_add` out 11: points to add, valid only while `ghost_eaten` is non-zero; otherwise 0.
- `life_lost` out 1: one-cycle pulse.
- `lives` out 2: remaining lives.
- `freeze` out 1: hold all actor movement.
- `respawn_req` out 1: request actor reload.
- `game_over` out 1: sticky until reset.

## Operation
- **Hit detection.** Ghost i hits when either condition holds:
  - Same position: (gx,gy)==(px,py).
  - Swap: current ghost position == previous player position, and current player position == previous ghost position.
- "Previous" is the value registered on the last clock where that position changed. Prev registers reload at reset and on `respawn_ack`.
- **States:** PLAY, FRIGHT, DYING, RESPAWN, OVER.
- **PLAY**
  - Any hit → DYING.
  - `power_eaten` → FRIGHT. Load `fright_left`=FRIGHT_TICKS, set chain=200, clear `eaten_mask`.
- **FRIGHT**
  - A hit by a ghost outside `eaten_mask` is latched into `pending`.
  - One pending ghost is serviced per cycle, lowest index first:
    - Pulse its `ghost_eaten` bit.
    - Drive `score_add`=chain.
    - Set its bit in `eaten_mask`.
    - Double the chain: 200→400→800→1600. The chain saturates at 1600.
  - A hit by a ghost already in `eaten_mask` is ignored.
  - `tick` decrements `fright_left`. When it reaches 0 → PLAY, clearing `eaten_mask` and `pending`.
  - `power_eaten` in FRIGHT reloads `fright_left` and resets chain to 200. `eaten_mask` is kept.
- **DYING**
  - On entry: pulse `life_lost`, decrement `lives`, assert `freeze`, load the freeze counter with HIT_FREEZE.
  - `tick` decrements the freeze counter. At 0:
    - `lives`==0 → OVER.
    - Otherwise → RESPAWN.
- **RESPAWN**
  - `freeze` and `respawn_req` are held high.
  - `respawn_ack` sampled high → PLAY next cycle, dropping both.
- **OVER**
  - `freeze`=1 and `game_over`=1 permanently.
- **Ignored inputs.** Hits and `power_eaten` are ignored in DYING, RESPAWN and OVER.
- **Simultaneous events.**
  - In PLAY, hit and `power_eaten` in the same cycle: the hit wins → DYING.
  - In FRIGHT, hit and `power_eaten` in the same cycle: the reload happens first, so the eat scores 200.
  - In FRIGHT, `tick` taking `fright_left` to 0 while `pending` is non-zero: pending ghosts are still serviced, one per cycle, before entering PLAY.

## Timing
- Inputs are sampled at the clock edge. All outputs are registered.
- A hit present at edge n produces the state change and pulses visible after edge n+1. This is 1-cycle latency.
- Eats from simultaneous hits appear on consecutive cycles, in index order.
- Reset values:
  - State=PLAY, `lives`=LIVES_INIT.
  - `frightened`=0, `fright_left`=0, `ghost_eaten`=0, `score_add`=0.
  - `life_lost`=0, `freeze`=0, `respawn_req`=0, `game_over`=0.
  - Prev registers = current inputs on the first clock after reset.
- Reset asserted mid-sequence (DYING, RESPAWN, OVER) returns everything to the reset values immediately. It does not wait for `tick`.
- `fright_left` and the freeze counter never underflow. A `tick` at 0 is a no-op.

## Structure
- Add to `define.v`:
  - State encodings `GS_PLAY`..`GS_OVER`.
  - Score constants 200/400/800/1600.
  - The existing `width_log2` / `height_log2` and `dir_*` definitions are reused.
- Sub-module `ghost_hit_detect`, instantiated 4×. Per ghost it holds the previous-position registers and produces a single hit bit.
- The top level holds the FSM, counters, chain, `eaten_mask` and `pending`.

## Test plan
- Ghost 2 at (200,240), player at (200,240) in PLAY → `life_lost` pulse 1 cycle later, `lives` 3→2, `freeze`=1. After 60 ticks, `respawn_req`=1. `respawn_ack` → PLAY next cycle.
- Player (140,160)→(160,160) while ghost (160,160)→(140,160) on the same clock → swap hit detected, DYING entered.
- `power_eaten`, then ghosts 0 and 3 hit on the same cycle → `ghost_eaten`=0001 with `score_add`=200, next cycle 1000 with 400. A re-hit by ghost 0 gives nothing.
- FRIGHT_TICKS=5 → `frightened` drops after the 5th tick. `power_eaten` after tick 3 reloads to 5 and the chain restarts at 200.
- LIVES_INIT=1, hit → after HIT_FREEZE ticks `game_over`=1 and `freeze`=1. Further hits, `power_eaten` and `respawn_ack` are ignored.
- `reset` low during RESPAWN → all outputs return to reset values asynchronously, `lives`=LIVES_INIT.

Source files
------------

// File: rtl/ghost_collision_ctrl_pkg.sv
// Shared definitions for the ghost collision controller:
// maze coordinate widths, game-state encodings and score chain.
package ghost_collision_ctrl_pkg;

  localparam int width_log2  = 10;
  localparam int height_log2 = 10;

  localparam logic [2:0] GS_PLAY    = 3'd0;
  localparam logic [2:0] GS_FRIGHT  = 3'd1;
  localparam logic [2:0] GS_DYING   = 3'd2;
  localparam logic [2:0] GS_RESPAWN = 3'd3;
  localparam logic [2:0] GS_OVER    = 3'd4;

  localparam logic [10:0] SCORE_200  = 11'd200;
  localparam logic [10:0] SCORE_400  = 11'd400;
  localparam logic [10:0] SCORE_800  = 11'd800;
  localparam logic [10:0] SCORE_1600 = 11'd1600;

  function automatic logic [10:0] chain_next(
    input logic [10:0] c
  );
    logic [10:0] n;
    n = SCORE_1600;
    if (c == SCORE_200)
      n = SCORE_400;
    else if (c == SCORE_400)
      n = SCORE_800;
    return n;
  endfunction

  function automatic logic [3:0] lowest_one(
    input logic [3:0] v
  );
    return v & (~v + 4'd1);
  endfunction

endpackage

// File: rtl/ghost_collision_ctrl_hit.sv
// Per-ghost hit detector: same-tile and pass-through swap,
// tracking the previous distinct position of ghost and player.
module ghost_hit_detect
  import ghost_collision_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_reload,
  input  logic [width_log2-1:0]  i_gx,
  input  logic [height_log2-1:0] i_gy,
  input  logic [width_log2-1:0]  i_px,
  input  logic [height_log2-1:0] i_py,
  output logic                   o_hit
);

  localparam int PW = width_log2 + height_log2;

  logic [PW-1:0] w_g;
  logic [PW-1:0] w_p;
  logic [PW-1:0] w_gprv;
  logic [PW-1:0] w_pprv;
  logic [PW-1:0] r_gcur;
  logic [PW-1:0] r_gprv;
  logic [PW-1:0] r_pcur;
  logic [PW-1:0] r_pprv;
  logic          r_vld;

  assign w_g = {i_gy, i_gx};
  assign w_p = {i_py, i_px};

  // a change seen this edge makes the last registered value "previous"
  always_comb begin
    w_gprv = r_gprv;
    w_pprv = r_pprv;
    if (!r_vld)
      w_gprv = w_g;
    else if (w_g != r_gcur)
      w_gprv = r_gcur;
    if (!r_vld)
      w_pprv = w_p;
    else if (w_p != r_pcur)
      w_pprv = r_pcur;
  end

  assign o_hit = (w_g == w_p) |
                 ((w_g == w_pprv) & (w_p == w_gprv));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gcur <= '0;
      r_gprv <= '0;
      r_pcur <= '0;
      r_pprv <= '0;
      r_vld  <= 1'b0;
    end else if (!r_vld || i_reload) begin
      r_gcur <= w_g;
      r_gprv <= w_g;
      r_pcur <= w_p;
      r_pprv <= w_p;
      r_vld  <= 1'b1;
    end else begin
      if (w_g != r_gcur) begin
        r_gprv <= r_gcur;
        r_gcur <= w_g;
      end
      if (w_p != r_pcur) begin
        r_pprv <= r_pcur;
        r_pcur <= w_p;
      end
    end
  end

endmodule

// File: rtl/ghost_collision_ctrl.sv
// Ghost/player collision controller: frightened timer, eat chain,
// lives and the freeze/respawn sequence.
module ghost_collision_ctrl
  import ghost_collision_ctrl_pkg::*;
#(
  parameter  int FRIGHT_TICKS = 300,
  parameter  int HIT_FREEZE   = 60,
  parameter  int LIVES_INIT   = 3,
  localparam int FLW = $clog2(FRIGHT_TICKS + 1),
  localparam int FZW = $clog2(HIT_FREEZE + 1)
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [width_log2-1:0]    player_x,
  input  logic [height_log2-1:0]   player_y,
  input  logic [4*width_log2-1:0]  ghost_x,
  input  logic [4*height_log2-1:0] ghost_y,
  input  logic                     power_eaten,
  input  logic                     respawn_ack,
  output logic                     frightened,
  output logic [FLW-1:0]           fright_left,
  output logic [3:0]               ghost_eaten,
  output logic [10:0]              score_add,
  output logic                     life_lost,
  output logic [1:0]               lives,
  output logic                     freeze,
  output logic                     respawn_req,
  output logic                     game_over
);

  logic [3:0]     w_hit;
  logic [2:0]     r_state;
  logic [FZW-1:0] r_frz;
  logic [10:0]    r_chain;
  logic [3:0]     r_eaten;
  logic [3:0]     r_pend;

  logic [10:0]    w_chain;
  logic [3:0]     w_cand;
  logic [3:0]     w_sel;
  logic [3:0]     w_rest;
  logic [FLW-1:0] w_fl;
  logic [FZW-1:0] w_frz;

  for (genvar g = 0; g < 4; g++) begin : g_hit
    ghost_hit_detect u_hit (
      .clk      (clk),
      .reset    (reset),
      .i_reload (respawn_ack),
      .i_gx     (ghost_x[g*width_log2 +: width_log2]),
      .i_gy     (ghost_y[g*height_log2 +: height_log2]),
      .i_px     (player_x),
      .i_py     (player_y),
      .o_hit    (w_hit[g])
    );
  end

  // a reload on power_eaten takes effect before this edge's eat
  always_comb begin
    w_chain = power_eaten ? SCORE_200 : r_chain;
    w_cand  = r_pend | (w_hit & ~r_eaten);
    w_sel   = lowest_one(w_cand);
    w_rest  = w_cand & ~w_sel;
    w_fl    = fright_left;
    if (power_eaten)
      w_fl = FLW'(FRIGHT_TICKS);
    else if (tick && fright_left != '0)
      w_fl = fright_left - FLW'(1);
    w_frz = r_frz;
    if (tick && r_frz != '0)
      w_frz = r_frz - FZW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= GS_PLAY;
      r_frz       <= '0;
      r_chain     <= SCORE_200;
      r_eaten     <= '0;
      r_pend      <= '0;
      frightened  <= 1'b0;
      fright_left <= '0;
      ghost_eaten <= '0;
      score_add   <= '0;
      life_lost   <= 1'b0;
      lives       <= 2'(LIVES_INIT);
      freeze      <= 1'b0;
      respawn_req <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      ghost_eaten <= '0;
      score_add   <= '0;
      life_lost   <= 1'b0;
      unique case (1'b1)
        r_state == GS_PLAY: begin
          if (|w_hit) begin
            r_state   <= GS_DYING;
            life_lost <= 1'b1;
            lives     <= lives - 2'd1;
            freeze    <= 1'b1;
            r_frz     <= FZW'(HIT_FREEZE);
          end else if (power_eaten) begin
            r_state     <= GS_FRIGHT;
            frightened  <= 1'b1;
            fright_left <= FLW'(FRIGHT_TICKS);
            r_chain     <= SCORE_200;
            r_eaten     <= '0;
            r_pend      <= '0;
          end
        end
        r_state == GS_FRIGHT: begin
          fright_left <= w_fl;
          r_chain     <= w_chain;
          r_pend      <= w_rest;
          if (|w_cand) begin
            ghost_eaten <= w_sel;
            score_add   <= w_chain;
            r_eaten     <= r_eaten | w_sel;
            r_chain     <= chain_next(w_chain);
          end
          if (w_fl == '0 && w_rest == '0) begin
            r_state    <= GS_PLAY;
            frightened <= 1'b0;
            r_eaten    <= '0;
          end
        end
        r_state == GS_DYING: begin
          r_frz <= w_frz;
          if (w_frz == '0) begin
            if (lives == 2'd0) begin
              r_state   <= GS_OVER;
              game_over <= 1'b1;
            end else begin
              r_state     <= GS_RESPAWN;
              respawn_req <= 1'b1;
            end
          end
        end
        r_state == GS_RESPAWN: begin
          if (respawn_ack) begin
            r_state     <= GS_PLAY;
            freeze      <= 1'b0;
            respawn_req <= 1'b0;
          end
        end
        r_state == GS_OVER: begin
          freeze    <= 1'b1;
          game_over <= 1'b1;
        end
        default: r_state <= GS_PLAY;
      endcase
    end
  end

endmodule
